// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Issue scheduler for a dual-issue core. Each cycle it looks at the decoded
//   slot0 (older) and slot1 (younger) pair and decides whether to issue both,
//   issue slot0 only, or stall. A per-register countdown scoreboard tracks
//   in-flight writes. The block also sequences the HALT drain.
// Ports
//   clk, rst_n      core clock, async active-low reset
//   pair_valid      ir0/ir1 hold a valid fetched pair
//   ir0, ir1        slot0 (older) / slot1 (younger) instruction words
//   flush           branch redirect: the current pair is wrong-path
//   issue0, issue1  per-slot issue strobes (issue1 implies issue0)
//   advance         0 hold, 1 shift ir1 into ir0, 2 take a new pair
//   stall           pair_valid and not issue0
//   halted          HALT retired and scoreboard drained (registered)
//   busy_mask       bit i = R[i] busy, bit 8 = status flags busy

// Per-slot decode: read/write masks over R0..R7 plus the status flags (bit 8).
module dis_decode (
  input  logic [15:0] ir,
  output logic [8:0]  rd_mask,
  output logic [8:0]  wr_mask,
  output logic        is_mem,
  output logic        is_br,
  output logic        is_halt,
  output logic        is_ld
);
  logic [2:0] opc;
  logic [1:0] op;
  logic [3:0] rn, rd, rm;
  logic       unused_bits;

  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = {1'b0, ir[10:8]};
  assign rd  = {1'b0, ir[7:5]};
  assign rm  = {1'b0, ir[2:0]};
  assign unused_bits = ^ir[4:3];

  always_comb begin
    rd_mask = '0;
    wr_mask = '0;
    is_mem  = 1'b0;
    is_br   = 1'b0;
    is_halt = 1'b0;
    is_ld   = 1'b0;
    case (opc)
      3'b110: begin
        if (op == 2'b10) wr_mask[rn] = 1'b1;
        else if (op == 2'b00) begin
          rd_mask[rm] = 1'b1;
          wr_mask[rd] = 1'b1;
        end
      end
      3'b101: begin
        case (op)
          2'b01: begin
            rd_mask[rn] = 1'b1;
            rd_mask[rm] = 1'b1;
            wr_mask[8]  = 1'b1;
          end
          2'b11: begin
            rd_mask[rm] = 1'b1;
            wr_mask[rd] = 1'b1;
          end
          default: begin
            rd_mask[rn] = 1'b1;
            rd_mask[rm] = 1'b1;
            wr_mask[rd] = 1'b1;
          end
        endcase
      end
      3'b011: begin
        rd_mask[rn] = 1'b1;
        wr_mask[rd] = 1'b1;
        is_mem      = 1'b1;
        is_ld       = 1'b1;
      end
      3'b100: begin
        rd_mask[rn] = 1'b1;
        rd_mask[rd] = 1'b1;
        is_mem      = 1'b1;
      end
      3'b001: begin
        rd_mask[8] = 1'b1;
        is_br      = 1'b1;
      end
      3'b010: begin
        is_br = 1'b1;
        case (op)
          2'b11: wr_mask[7] = 1'b1;
          2'b00: rd_mask[rd] = 1'b1;
          2'b10: begin
            rd_mask[rd] = 1'b1;
            wr_mask[7]  = 1'b1;
          end
          default: ;
        endcase
      end
      3'b111: is_halt = 1'b1;
      default: ;
    endcase
  end
endmodule

module dual_issue_scheduler #(
  parameter int ALU_LAT = 2,
  parameter int LD_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pair_valid,
  input  logic [15:0] ir0,
  input  logic [15:0] ir1,
  input  logic        flush,
  output logic        issue0,
  output logic        issue1,
  output logic [1:0]  advance,
  output logic        stall,
  output logic        halted,
  output logic [8:0]  busy_mask
);
  localparam int NSB = 9;
  localparam int CW  = $clog2(LD_LAT + 1);
  localparam logic [CW-1:0] ALU_LD = CW'(ALU_LAT);
  localparam logic [CW-1:0] LD_LD  = CW'(LD_LAT);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic                   halted_q, halted_d;
  logic [NSB-1:0][CW-1:0] cnt_q, cnt_d;

  logic [1:0][15:0]    ir;
  logic [1:0][NSB-1:0] rd_m, wr_m;
  logic [1:0]          is_mem, is_br, is_halt, is_ld;
  logic [NSB-1:0]      hz;
  logic                ok0, ok1;
  logic                unused_br;

  assign ir        = {ir1, ir0};
  assign unused_br = is_br[1];

  for (genvar s = 0; s < 2; s++) begin : g_dec
    dis_decode u_dec (
      .ir      (ir[s]),
      .rd_mask (rd_m[s]),
      .wr_mask (wr_m[s]),
      .is_mem  (is_mem[s]),
      .is_br   (is_br[s]),
      .is_halt (is_halt[s]),
      .is_ld   (is_ld[s])
    );
  end

  // A counter of 1 means the result lands on the bypass this cycle, so a new
  // issue only has to wait while the count is above 1. busy_mask still shows
  // every nonzero counter, which is what the drain waits on.
  for (genvar i = 0; i < NSB; i++) begin : g_sb
    assign busy_mask[i] = (cnt_q[i] != '0);
    assign hz[i]        = (cnt_q[i] > CW'(1));
  end

  always_comb begin
    ok0 = rst_n && pair_valid && !flush && (state_q == RUN) &&
          !(|((rd_m[0] | wr_m[0]) & hz));
    ok1 = !(|((rd_m[1] | wr_m[1]) & hz)) &&
          !(|(rd_m[1] & wr_m[0])) &&
          !(|(wr_m[1] & wr_m[0])) &&
          !(is_mem[0] && is_mem[1]) &&
          !is_br[0] && !is_halt[0] && !is_halt[1];
    issue0  = ok0;
    issue1  = ok0 && ok1;
    advance = issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0);
    stall   = rst_n && pair_valid && !issue0;
  end

  // Slot0/slot1 never share a destination when both issue, so the two loads
  // cannot collide on one counter.
  always_comb begin
    for (int i = 0; i < NSB; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
      if (issue1 && wr_m[1][i]) cnt_d[i] = is_ld[1] ? LD_LD : ALU_LD;
      if (issue0 && wr_m[0][i]) cnt_d[i] = is_ld[0] ? LD_LD : ALU_LD;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      RUN:    if (issue0 && is_halt[0]) state_d = DRAIN;
      DRAIN:  if (busy_mask == '0) begin
                state_d  = HALTED;
                halted_d = 1'b1;
              end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign halted = halted_q;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pair_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] ir0 = 16'h0;
  logic [15:0] ir1 = 16'h0;
  logic        issue0, issue1, stall, halted;
  logic [1:0]  advance;
  logic [8:0]  busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       i0;
    logic       i1;
    logic [1:0] adv;
    logic       st;
    logic [8:0] bm;
    logic       h;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [15:0] NOP   = 16'h0000;
  localparam logic [15:0] MOVR1 = 16'hD102;
  localparam logic [15:0] MOVR2 = 16'hD202;
  localparam logic [15:0] ADD   = 16'hA143;
  localparam logic [15:0] LDR   = 16'h6120;
  localparam logic [15:0] STR   = 16'h8220;
  localparam logic [15:0] CMP   = 16'hA902;
  localparam logic [15:0] BR    = 16'h2000;
  localparam logic [15:0] HALT  = 16'hE000;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.ALU_LAT(2), .LD_LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pair_valid (pair_valid),
    .ir0        (ir0),
    .ir1        (ir1),
    .flush      (flush),
    .issue0     (issue0),
    .issue1     (issue1),
    .advance    (advance),
    .stall      (stall),
    .halted     (halted),
    .busy_mask  (busy_mask)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle just after the rising edge, queue its expectation, and
  // check the DUT on the falling edge of the same cycle.
  task automatic step(input string tag, input logic r, input logic pv,
                      input logic [15:0] a, input logic [15:0] b, input logic fl,
                      input logic e0, input logic e1, input logic [1:0] eadv,
                      input logic est, input logic [8:0] ebm, input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; pair_valid = pv; ir0 = a; ir1 = b; flush = fl;
    e.i0 = e0; e.i1 = e1; e.adv = eadv; e.st = est; e.bm = ebm; e.h = eh;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".issue0"},    16'(issue0),    16'(e.i0));
    chk({tag, ".issue1"},    16'(issue1),    16'(e.i1));
    chk({tag, ".advance"},   16'(advance),   16'(e.adv));
    chk({tag, ".stall"},     16'(stall),     16'(e.st));
    chk({tag, ".busy_mask"}, 16'(busy_mask), 16'(e.bm));
    chk({tag, ".halted"},    16'(halted),    16'(e.h));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    //    tag     rst pv  ir0    ir1   fl  i0 i1 adv st  busy    h
    step("rst",   0, 1, MOVR1, NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 1) independent pair dual-issues; R1 busy for ALU_LAT cycles
    step("t1a",   1, 1, MOVR1, NOP,  0,  1, 1, 2, 0, 9'h000, 0);
    step("t1b",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h002, 0);
    step("t1c",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h002, 0);
    step("t1d",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 2) RAW inside pair splits; re-presented ADD stalls ALU_LAT-1 cycles
    step("t2a",   1, 1, MOVR1, ADD,  0,  1, 0, 1, 0, 9'h000, 0);
    step("t2b",   1, 1, ADD,   NOP,  0,  0, 0, 0, 1, 9'h002, 0);
    step("t2c",   1, 1, ADD,   NOP,  0,  1, 1, 2, 0, 9'h002, 0);
    step("t2d",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h004, 0);
    step("t2e",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h004, 0);
    step("t2f",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 3) memory pair splits; STR reading R1 waits LD_LAT cycles after LDR
    step("t3a",   1, 1, LDR,   STR,  0,  1, 0, 1, 0, 9'h000, 0);
    step("t3b",   1, 1, STR,   NOP,  0,  0, 0, 0, 1, 9'h002, 0);
    step("t3c",   1, 1, STR,   NOP,  0,  0, 0, 0, 1, 9'h002, 0);
    step("t3d",   1, 1, STR,   NOP,  0,  1, 1, 2, 0, 9'h002, 0);
    step("t3e",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 4) CMP/B split; B waits on status, then issues alone
    step("t4a",   1, 1, CMP,   BR,   0,  1, 0, 1, 0, 9'h000, 0);
    step("t4b",   1, 1, BR,    NOP,  0,  0, 0, 0, 1, 9'h100, 0);
    step("t4c",   1, 1, BR,    NOP,  0,  1, 0, 1, 0, 9'h100, 0);
    step("t4d",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 5) flush blocks issue while the scoreboard keeps counting down
    step("t5a",   1, 1, MOVR1, NOP,  0,  1, 1, 2, 0, 9'h000, 0);
    step("t5b",   1, 1, MOVR2, NOP,  1,  0, 0, 0, 1, 9'h002, 0);
    step("t5c",   1, 1, MOVR2, NOP,  1,  0, 0, 0, 1, 9'h002, 0);
    step("t5d",   1, 1, MOVR2, NOP,  0,  1, 1, 2, 0, 9'h000, 0);
    step("t5e",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h004, 0);
    step("t5f",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h004, 0);
    step("t5g",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // 6) HALT behind an in-flight LDR drains, then halts one cycle after idle
    step("t6a",   1, 1, LDR,   HALT, 0,  1, 0, 1, 0, 9'h000, 0);
    step("t6b",   1, 1, HALT,  NOP,  0,  1, 0, 1, 0, 9'h002, 0);
    step("t6c",   1, 1, NOP,   NOP,  0,  0, 0, 0, 1, 9'h002, 0);
    step("t6d",   1, 1, NOP,   NOP,  0,  0, 0, 0, 1, 9'h002, 0);
    step("t6e",   1, 1, NOP,   NOP,  0,  0, 0, 0, 1, 9'h000, 0);
    step("t6f",   1, 1, NOP,   NOP,  0,  0, 0, 0, 1, 9'h000, 1);
    step("t6g",   0, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    // mid-DRAIN reset clears counters at once and returns to RUN
    step("t6h",   1, 1, LDR,   HALT, 0,  1, 0, 1, 0, 9'h000, 0);
    step("t6i",   1, 1, HALT,  NOP,  0,  1, 0, 1, 0, 9'h002, 0);
    step("t6j",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h002, 0);
    step("t6k",   0, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h000, 0);
    step("t6l",   1, 1, MOVR2, NOP,  0,  1, 1, 2, 0, 9'h000, 0);
    step("t6m",   1, 0, NOP,   NOP,  0,  0, 0, 0, 0, 9'h004, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
